// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One add-and-shift per clock with a Start/Busy/Done handshake.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               Start,
  input  logic [WIDTH-1:0]   MultA,
  input  logic [WIDTH-1:0]   MultB,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_count;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_accept;
  logic             w_last;

  // Carry-out of the add lands in the Hi MSB after the shift, so no bit is lost.
  always_comb begin
    w_addend = r_lo[0] ? r_mcand : '0;
    w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    w_hi_nxt = w_sum[WIDTH:1];
    w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    w_last   = (r_count == CW'(WIDTH - 1));
    w_accept = Start && ((r_state == IDLE) || (r_state == DONE));
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    Busy   = 1'b0;
    Done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        Done   = 1'b1;
        w_next = w_accept ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand <= MultA;
      r_lo    <= MultB;
      r_hi    <= '0;
      r_count <= '0;
    end else if (r_state == RUN) begin
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_count <= r_count + 1'b1;
      if (w_last) r_product <= {w_hi_nxt, w_lo_nxt};
    end
  end

  assign Product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed plan cases plus random
// operands checked against a plain a*b reference and latency expectations.
module tb_seq_multiplier;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 1;

  logic           Clk;
  logic           ResetN;
  logic           Start;
  logic [W-1:0]   MultA;
  logic [W-1:0]   MultB;
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] Product;

  int n_checks = 0;
  int n_fail   = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Start  (Start),
    .MultA  (MultA),
    .MultB  (MultB),
    .Busy   (Busy),
    .Done   (Done),
    .Product(Product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa;
    logic [2*W-1:0] wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    return wa * wb;
  endfunction

  // Stimulus only: issues one operation from IDLE and measures it; operands
  // are scrambled after acceptance. lat is cycles from accept to Done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int nbusy, output logic [2*W-1:0] prod);
    @(negedge Clk);
    Start = 1'b1;
    MultA = a;
    MultB = b;
    lat   = 0;
    nbusy = 0;
    prod  = 'x;
    for (int c = 1; c <= 3 * LAT; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      MultA = $urandom;
      MultB = $urandom;
      lat   = c;
      if (Busy) nbusy++;
      if (Done) begin
        prod = Product;
        break;
      end
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    Start  = 1'b1;
    MultA  = 5;
    MultB  = 5;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_checks++;
    if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_checks++;
    if (Product !== '0) begin n_fail++; $display("FAIL reset_product: got %h want 0", Product); end
    ResetN = 1'b1;
    Start  = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy %b want 0", Busy); end
  endtask

  task automatic test_directed();
    logic [W-1:0]   av [4] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    logic [W-1:0]   bv [4] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h1234_5678, 32'h89AB_CDEF};
    logic [2*W-1:0] ev [4] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFE_0000_0001,
                               64'h0, 64'h0000_0000_89AB_CDEF};
    int lat, nbusy;
    logic [2*W-1:0] prod;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], lat, nbusy, prod);
      n_checks++;
      if (prod !== ev[i]) begin
        n_fail++; $display("FAIL directed_%0d_product: got %h want %h", i, prod, ev[i]);
      end
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, LAT); end
      n_checks++;
      if (nbusy != W) begin n_fail++; $display("FAIL directed_%0d_busy_cycles: got %0d want %0d", i, nbusy, W); end
      @(negedge Clk);
      n_checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        n_fail++; $display("FAIL directed_%0d_done_pulse: done %b busy %b want 0 0", i, Done, Busy);
      end
      n_checks++;
      if (Product !== ev[i]) begin
        n_fail++; $display("FAIL directed_%0d_hold: got %h want %h", i, Product, ev[i]);
      end
    end
  endtask

  task automatic test_start_during_run();
    int dones = 0, done_at = 0;
    logic busy_after = 1'b0;
    logic [2*W-1:0] prod = 'x;
    @(negedge Clk);
    Start = 1'b1; MultA = 7; MultB = 9;
    for (int c = 1; c <= 50; c++) begin
      @(negedge Clk);
      Start = (c == 10);
      if (c == 10) begin MultA = 2; MultB = 2; end
      else if (c > 10) begin MultA = $urandom; MultB = $urandom; end
      if (Done) begin dones++; done_at = c; prod = Product; end
      if (c > LAT && Busy) busy_after = 1'b1;
    end
    Start = 1'b0;
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL sdr_done_count: got %0d want 1", dones); end
    n_checks++;
    if (done_at != LAT) begin n_fail++; $display("FAIL sdr_done_cycle: got %0d want %0d", done_at, LAT); end
    n_checks++;
    if (prod !== 64'h3F) begin n_fail++; $display("FAIL sdr_product: got %h want 3f", prod); end
    n_checks++;
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL sdr_no_second_op: got busy %b want 0", busy_after); end
  endtask

  task automatic test_back_to_back();
    int done_cyc [2] = '{0, 0};
    logic [2*W-1:0] done_prod [2];
    int nd = 0;
    logic hold_ok = 1'b1;
    logic busy34 = 1'b0;
    @(negedge Clk);
    Start = 1'b1; MultA = 6; MultB = 7;
    for (int c = 1; c <= 2 * LAT + 6; c++) begin
      @(negedge Clk);
      if (c == 1) begin MultA = 32'h0001_0000; MultB = 32'h0001_0000; end
      if (c == LAT + 1) begin Start = 1'b0; busy34 = Busy; end
      if (Done) begin
        if (nd < 2) begin done_cyc[nd] = c; done_prod[nd] = Product; end
        nd++;
      end
      if (c > LAT && c < 2 * LAT && Product !== 64'h2A) hold_ok = 1'b0;
    end
    n_checks++;
    if (nd != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
    n_checks++;
    if (done_cyc[0] != LAT || done_prod[0] !== 64'h2A) begin
      n_fail++; $display("FAIL b2b_first: cycle %0d product %h want %0d 2a", done_cyc[0], done_prod[0], LAT);
    end
    n_checks++;
    if (busy34 !== 1'b1) begin n_fail++; $display("FAIL b2b_no_bubble: busy %b want 1", busy34); end
    n_checks++;
    if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_product_hold: got %b want 1", hold_ok); end
    n_checks++;
    if (done_cyc[1] != 2 * LAT || done_prod[1] !== 64'h0000_0001_0000_0000) begin
      n_fail++; $display("FAIL b2b_second: cycle %0d product %h want %0d 100000000", done_cyc[1], done_prod[1], 2 * LAT);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0, lat, nbusy;
    logic [2*W-1:0] prod;
    @(negedge Clk);
    Start = 1'b1; MultA = 32'hDEAD_BEEF; MultB = 2;
    for (int c = 1; c <= 50; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (c == 15) ResetN = 1'b0;
      if (c == 16) begin
        ResetN = 1'b1;
        n_checks++;
        if (Busy !== 1'b0 || Product !== '0) begin
          n_fail++; $display("FAIL rmid_cleared: busy %b product %h want 0 0", Busy, Product);
        end
      end
      if (Done) dones++;
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d want 0", dones); end
    run_op(4, 4, lat, nbusy, prod);
    n_checks++;
    if (prod !== 64'h10 || lat != LAT) begin
      n_fail++; $display("FAIL rmid_fresh_op: product %h lat %0d want 10 %0d", prod, lat, LAT);
    end
  endtask

  task automatic test_random();
    int lat, nbusy;
    logic [W-1:0] a, b;
    logic [2*W-1:0] prod;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) a = '1;
      if (i == 1) b = '1;
      run_op(a, b, lat, nbusy, prod);
      n_checks++;
      if (prod !== ref_mul(a, b) || lat != LAT) begin
        n_fail++;
        $display("FAIL random_%0d: %h*%h got %h lat %0d want %h lat %0d", i, a, b, prod, lat, ref_mul(a, b), LAT);
      end
    end
  endtask

  initial begin
    ResetN = 1'b0;
    Start  = 1'b0;
    MultA  = '0;
    MultB  = '0;
    test_reset();
    test_directed();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
